// File: rtl/sum_exchange_fifo.sv
// Receive-side buffer for the cross-core partial-sum exchange: collects the peer's
// row sums, flags the local controller once the full vector is held, then drains on NORM.
module sum_exchange_fifo #(
  parameter int bw       = 8,
  parameter int bw_psum  = 2*bw+4,
  parameter int dw       = bw_psum+4,
  parameter int depth    = 16,
  parameter int wr_lat   = 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [dw-1:0]           peer_sum,
  input  logic                    peer_rd,
  input  logic                    div_o,
  output logic [dw-1:0]           sum_in,
  output logic                    fifo_in_ready,
  output logic [$clog2(depth):0]  count,
  output logic                    overflow,
  output logic                    underflow
);

  localparam int AW = $clog2(depth);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL = CW'(depth);

  typedef enum logic [1:0] {COLLECT, READY, DRAIN} state_t;

  state_t          state_q;
  logic [dw-1:0]   mem_q [depth];
  logic [AW-1:0]   wptr_q, rptr_q;
  logic [CW-1:0]   count_q, count_d;
  logic [dw-1:0]   sum_q;
  logic            ready_q, ovf_q, unf_q;
  logic            wr_en, do_wr, do_rd;

  // The peer's sum word trails its read strobe, so the strobe is aligned to the data here.
  generate
    if (wr_lat == 0) begin : g_nolat
      assign wr_en = peer_rd;
    end else begin : g_lat
      logic [wr_lat-1:0] rd_dly_q;
      if (wr_lat == 1) begin : g_one
        always_ff @(posedge clk) begin
          if (reset) rd_dly_q <= '0;
          else       rd_dly_q <= peer_rd;
        end
      end else begin : g_multi
        always_ff @(posedge clk) begin
          if (reset) rd_dly_q <= '0;
          else       rd_dly_q <= {rd_dly_q[wr_lat-2:0], peer_rd};
        end
      end
      assign wr_en = rd_dly_q[wr_lat-1];
    end
  endgenerate

  always_comb begin
    do_wr   = wr_en && (count_q != FULL);
    do_rd   = div_o && (count_q != '0);
    count_d = count_q;
    if (do_wr && !do_rd)      count_d = count_q + CW'(1);
    else if (!do_wr && do_rd) count_d = count_q - CW'(1);
  end

  always_ff @(posedge clk) begin
    if (!reset && do_wr) mem_q[wptr_q] <= peer_sum;
  end

  // A write to the slot being read lands after the read, so the old word is returned.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= COLLECT;
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      sum_q   <= '0;
      ready_q <= 1'b0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      if (do_wr) wptr_q <= wptr_q + 1'b1;
      if (do_rd) begin
        sum_q  <= mem_q[rptr_q];
        rptr_q <= rptr_q + 1'b1;
      end
      if (wr_en && count_q == FULL) ovf_q <= 1'b1;
      if (div_o && count_q == '0)   unf_q <= 1'b1;
      case (state_q)
        COLLECT: begin
          if (count_d == FULL) begin
            state_q <= READY;
            ready_q <= 1'b1;
          end
        end
        READY: begin
          if (div_o) begin
            ready_q <= 1'b0;
            state_q <= (count_d == '0) ? COLLECT : DRAIN;
          end
        end
        DRAIN: begin
          if (count_d == '0) state_q <= COLLECT;
        end
        default: begin
          state_q <= COLLECT;
          ready_q <= 1'b0;
        end
      endcase
    end
  end

  assign sum_in        = sum_q;
  assign fifo_in_ready = ready_q;
  assign count         = count_q;
  assign overflow      = ovf_q;
  assign underflow     = unf_q;

endmodule
